// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, divide and branch stalls into front-end enables.
// Mealy outputs in RUN; divide holds the front end for DIV_CYCLES cycles; branch flush spans 2 cycles.
module pipe_stall_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] EX_write_addr,
    input  logic [ADDR_W-1:0] DE_op1_addr,
    input  logic [ADDR_W-1:0] DE_op2_addr,
    input  logic              EX_readbit,
    input  logic              DE_div,
    input  logic              EX_branch_taken,
    output logic              fetchbuffenable,
    output logic              pcenable,
    output logic              zerocontrol,
    output logic              flush,
    output logic              div_go,
    output logic              div_wb,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int DW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic hz;
    logic hold;
    logic flush_o;
    logic zc_o;
    logic go_o;
    logic wb_o;

    assign hz = !EX_readbit &&
                ((EX_write_addr == DE_op1_addr) || (EX_write_addr == DE_op2_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            div_cnt_q     <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            RUN: begin
                if (EX_branch_taken) begin
                    state_d = FLUSH;
                end else if (hz) begin
                    state_d = RUN;
                end else if (DE_div) begin
                    state_d   = DIV_WAIT;
                    div_cnt_d = DW'(DIV_CYCLES - 1);
                end
            end
            DIV_WAIT: begin
                div_cnt_d = div_cnt_q - DW'(1);
                if (div_cnt_q == DW'(1)) begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Reset forces every output low, overriding any in-flight divide or flush.
    always_comb begin
        hold    = 1'b0;
        flush_o = 1'b0;
        zc_o    = 1'b0;
        go_o    = 1'b0;
        wb_o    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (EX_branch_taken) begin
                        flush_o = 1'b1;
                    end else if (hz) begin
                        hold = 1'b1;
                        zc_o = 1'b1;
                    end else if (DE_div) begin
                        hold = 1'b1;
                        zc_o = 1'b1;
                        go_o = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    hold = 1'b1;
                    zc_o = 1'b1;
                    wb_o = (div_cnt_q == DW'(1));
                end
                FLUSH: begin
                    flush_o = 1'b1;
                    zc_o    = 1'b1;
                end
                default: begin
                    hold = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hold && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign fetchbuffenable = hold;
    assign pcenable        = hold;
    assign zerocontrol     = zc_o;
    assign flush           = flush_o;
    assign div_go          = go_o;
    assign div_wb          = wb_o;
    assign stall_count     = rst ? '0 : stall_count_q;

endmodule
